// File: rtl/tetris_pkg.sv
// Shared playfield geometry, cell/row types and the controller state encoding.
// Geometry: ROWS x COLS cells, each CW bits wide; row 0 is the top row, column 0 the left column.
// Helpers build an all-empty row and test a row for any occupied cell.
package tetris_pkg;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CW   = 7;

  localparam logic [CW-1:0] EMPTY = 7'd0;

  typedef logic [CW-1:0]    cell_t;
  typedef cell_t [COLS-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WRITE,
    SCAN,
    FILL,
    DONE
  } state_t;

  function automatic row_t empty_row();
    row_t r;
    for (int c = 0; c < COLS; c++) r[c] = EMPTY;
    return r;
  endfunction

  function automatic logic row_nonempty(input row_t r);
    logic any;
    any = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (r[c] != EMPTY) any = 1'b1;
    end
    return any;
  endfunction

endpackage

// File: rtl/field_controller_row_full_detect.sv
// Combinational full-row detector: full is high when no cell of the row is EMPTY.
// Ports: row (one playfield row) in, full out.
// No state, no latency.
module row_full_detect
  import tetris_pkg::*;
(
  input  row_t row,
  output logic full
);

  always_comb begin
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (row[c] == EMPTY) full = 1'b0;
    end
  end

endmodule

// File: rtl/field_controller.sv
// Owns the Tetris playfield: locks pieces, removes full rows, compacts and clears the field.
// Ports: lock_req/lock_row/lock_col/lock_color + lock_ack handshake, clear_req, busy/done status,
//        lines_cleared/total_lines/top_out to scoring, field_color live array to the renderer.
module field_controller
  import tetris_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                lock_req,
  input  logic [3:0][4:0]     lock_row,
  input  logic [3:0][3:0]     lock_col,
  input  logic [CW-1:0]       lock_color,
  input  logic                clear_req,
  output logic                lock_ack,
  output logic                busy,
  output logic                done,
  output logic [2:0]          lines_cleared,
  output logic [15:0]         total_lines,
  output logic                top_out,
  output row_t [ROWS-1:0]     field_color
);

  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
  localparam logic [3:0]        LAST_COL = 4'(COLS - 1);
  localparam logic signed [5:0] ROW_INIT = 6'(ROWS - 1);

  state_t state, state_next;

  row_t field [ROWS];

  // Piece captured on the ack cycle so the requester may drop its inputs.
  logic [3:0][4:0] row_q;
  logic [3:0][3:0] col_q;
  cell_t           color_q;
  logic            op_clear;

  // Signed row pointers: stepping below row 0 yields -1 rather than wrapping.
  logic signed [5:0] src;
  logic signed [5:0] dst;
  logic [4:0]        cnt;

  row_t        scan_row;
  logic        scan_full;
  logic [16:0] total_sum;
  logic [15:0] total_next;

  always_comb begin
    scan_row = empty_row();
    if (!src[5] && src[4:0] <= LAST_ROW) scan_row = field[src[4:0]];
  end

  row_full_detect u_row_full (
    .row  (scan_row),
    .full (scan_full)
  );

  assign total_sum  = {1'b0, total_lines} + {12'd0, cnt};
  assign total_next = total_sum[16] ? 16'hFFFF : total_sum[15:0];

  always_comb begin
    for (int r = 0; r < ROWS; r++) field_color[r] = field[r];
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clear_req)     state_next = CLEAR;
        else if (lock_req) state_next = WRITE;
      end
      CLEAR: state_next = DONE;
      WRITE: state_next = SCAN;
      SCAN: begin
        // Rows left to blank after the last scanned row equal the cleared count.
        if (src == 6'sd0) state_next = (scan_full || cnt != 5'd0) ? FILL : DONE;
      end
      FILL: begin
        if (dst == 6'sd0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------- control and counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lock_ack      <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= 3'd0;
      total_lines   <= 16'd0;
      top_out       <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      color_q       <= EMPTY;
      op_clear      <= 1'b0;
      src           <= 6'sd0;
      dst           <= 6'sd0;
      cnt           <= 5'd0;
    end else begin
      lock_ack <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            op_clear <= 1'b1;
          end else if (lock_req) begin
            lock_ack <= 1'b1;
            row_q    <= lock_row;
            col_q    <= lock_col;
            color_q  <= lock_color;
            op_clear <= 1'b0;
          end
        end
        CLEAR: begin
          top_out       <= 1'b0;
          total_lines   <= 16'd0;
          lines_cleared <= 3'd0;
        end
        WRITE: begin
          src <= ROW_INIT;
          dst <= ROW_INIT;
          cnt <= 5'd0;
        end
        SCAN: begin
          src <= src - 6'sd1;
          if (scan_full) cnt <= cnt + 5'd1;
          else           dst <= dst - 6'sd1;
        end
        FILL: begin
          dst <= dst - 6'sd1;
        end
        DONE: begin
          done <= 1'b1;
          if (!op_clear) begin
            lines_cleared <= (cnt > 5'd7) ? 3'd7 : cnt[2:0];
            total_lines   <= total_next;
          end
          top_out <= top_out | row_nonempty(field[0]);
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------ field array
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < ROWS; r++) field[r] <= empty_row();
    end else begin
      case (state)
        CLEAR: begin
          for (int r = 0; r < ROWS; r++) field[r] <= empty_row();
        end
        WRITE: begin
          // Later cells override earlier ones on duplicate coordinates.
          for (int i = 0; i < 4; i++) begin
            if (row_q[i] <= LAST_ROW && col_q[i] <= LAST_COL)
              field[row_q[i]][col_q[i]] <= color_q;
          end
        end
        SCAN: begin
          if (!scan_full && dst != src) field[dst[4:0]] <= scan_row;
        end
        FILL: begin
          field[dst[4:0]] <= empty_row();
        end
        default: ;
      endcase
    end
  end

endmodule
